alu_muldiv_seq: RTL

ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

---
 rtl/alu_muldiv_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq
// Description : Iterative RV-style multiply/divide unit. Radix-2 shift-add
//               multiply and restoring divide on operand magnitudes.
// Revision    : 1.0
// ============================================================================
module alu_muldiv_seq #(
    parameter int XLEN         = 32,
    parameter int FAST_SPECIAL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out
);

    localparam int                c_cnt_w    = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(XLEN - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [XLEN-1:0]   c_min      = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2:0]        c_op_mul    = 3'd0;
    localparam logic [2:0]        c_op_mulh   = 3'd1;
    localparam logic [2:0]        c_op_mulhsu = 3'd2;
    localparam logic [2:0]        c_op_div    = 3'd4;
    localparam logic [2:0]        c_op_rem    = 3'd6;
    localparam bit                c_fast      = (FAST_SPECIAL != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_op;
    logic [XLEN-1:0]      r_hi;
    logic [XLEN-1:0]      r_lo;
    logic [XLEN-1:0]      r_b;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_neg;
    logic                 r_spec;
    logic [XLEN-1:0]      r_out;

    // Request decode: operand signedness, magnitudes, special cases
    logic                 w_accept;
    logic                 w_a_signed;
    logic                 w_b_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [XLEN-1:0]      w_a_mag;
    logic [XLEN-1:0]      w_b_mag;
    logic                 w_res_neg;
    logic                 w_div0;
    logic                 w_ovf;
    logic                 w_special;
    logic [XLEN-1:0]      w_spec_res;

    assign w_accept   = (r_state == IDLE) && in_valid && !flush;
    assign w_a_signed = (md_op == c_op_mulh) || (md_op == c_op_mulhsu) ||
                        (md_op == c_op_div)  || (md_op == c_op_rem);
    assign w_b_signed = (md_op == c_op_mulh) || (md_op == c_op_div) || (md_op == c_op_rem);
    assign w_a_neg    = w_a_signed && rs1[XLEN-1];
    assign w_b_neg    = w_b_signed && rs2[XLEN-1];
    assign w_a_mag    = w_a_neg ? -rs1 : rs1;
    assign w_b_mag    = w_b_neg ? -rs2 : rs2;
    // Remainder takes the dividend sign; everything else the XOR of signs
    assign w_res_neg  = (md_op == c_op_rem) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_div0     = md_op[2] && (rs2 == '0);
    assign w_ovf      = md_op[2] && !md_op[0] && (rs1 == c_min) && (rs2 == '1);
    assign w_special  = w_div0 || w_ovf;
    assign w_spec_res = md_op[1] ? (w_div0 ? rs1 : '0) : (w_div0 ? '1 : rs1);

    // One iteration step for multiply and divide
    logic [XLEN:0]        w_sum;
    logic [XLEN:0]        w_rem_sh;
    logic                 w_ge;
    logic [XLEN-1:0]      w_diff;
    logic [XLEN-1:0]      w_hi_nxt;
    logic [XLEN-1:0]      w_lo_nxt;

    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_b});
    assign w_diff   = w_rem_sh[XLEN-1:0] - r_b;
    assign w_hi_nxt = r_op[2] ? (w_ge ? w_diff : w_rem_sh[XLEN-1:0]) : w_sum[XLEN:1];
    assign w_lo_nxt = r_op[2] ? {r_lo[XLEN-2:0], w_ge} : {w_sum[0], r_lo[XLEN-1:1]};

    // Final selection uses the post-step values of the last iteration
    logic [2*XLEN-1:0]    w_prod;
    logic [2*XLEN-1:0]    w_prod_s;
    logic [XLEN-1:0]      w_div_sel;
    logic [XLEN-1:0]      w_div_s;
    logic [XLEN-1:0]      w_final;

    assign w_prod    = {w_hi_nxt, w_lo_nxt};
    assign w_prod_s  = r_neg ? -w_prod : w_prod;
    assign w_div_sel = r_op[1] ? w_hi_nxt : w_lo_nxt;
    assign w_div_s   = r_neg ? -w_div_sel : w_div_sel;
    assign w_final   = r_op[2] ? w_div_s :
                       (r_op == c_op_mul) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = (c_fast && w_special) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (flush) begin
            w_state_nxt = IDLE;
        end
    end

    assign out = out_valid ? r_out : '0;

    // Special-case results are parked in r_out at accept; out is gated by state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_neg  <= 1'b0;
            r_spec <= 1'b0;
            r_out  <= '0;
        end else if (w_accept) begin
            r_op   <= md_op;
            r_hi   <= '0;
            r_lo   <= w_a_mag;
            r_b    <= w_b_mag;
            r_cnt  <= c_cnt_init;
            r_neg  <= w_res_neg;
            r_spec <= w_special;
            if (w_special) begin
                r_out <= w_spec_res;
            end
        end else if (r_state == BUSY) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_cnt_one;
            end else if (!r_spec) begin
                r_out <= w_final;
            end
        end
    end

endmodule
`default_nettype wire
